// File: rtl/full_adder_pkg.sv
// Shared constants and a plain-arithmetic reference for the ripple-carry adder.
package full_adder_pkg;

   localparam int unsigned MAX_WIDTH = 64;

   // Returns {cout, sum} for a width-bit add; sum bits above width are zero.
   function automatic logic [MAX_WIDTH:0] ref_add(input logic [MAX_WIDTH-1:0] a,
                                                   input logic [MAX_WIDTH-1:0] b,
                                                   input logic                 cin,
                                                   input int unsigned          width);
      logic [MAX_WIDTH:0]   t;
      logic [MAX_WIDTH-1:0] m;
      t = {1'b0, a} + {1'b0, b} + (MAX_WIDTH+1)'(cin);
      m = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
      return {t[7'(width)], t[MAX_WIDTH-1:0] & m};
   endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand, control and result bundle for full_adder.
interface full_adder_if #(parameter int unsigned WIDTH = 1);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             en;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   modport master (output a, b, cin, en,
                   input  sum, cout, sum_q, cout_q, ovf_q);

   modport slave  (input  a, b, cin, en,
                   output sum, cout, sum_q, cout_q, ovf_q);

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder: the leaf of the carry chain.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational result and an enabled,
// async-reset registered copy including signed overflow.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic         clk,
   input  logic         rst,
   full_adder_if.slave  bus
);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $fatal(1, "full_adder: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
   end

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic             ovf_c;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   assign c[0] = bus.cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_cell u_cell (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign ovf_c = c[WIDTH] ^ c[WIDTH-1];

   assign bus.sum  = s;
   assign bus.cout = c[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r  <= '0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (bus.en) begin
         sum_r  <= s;
         cout_r <= c[WIDTH];
         ovf_r  <= ovf_c;
      end
   end

   assign bus.sum_q  = sum_r;
   assign bus.cout_q = cout_r;
   assign bus.ovf_q  = ovf_r;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 8 and 32 driven in lock-step.
module tb_full_adder;
   import full_adder_pkg::*;

   localparam int unsigned N_DUT  = 3;
   localparam int unsigned N_RAND = 10000;

   typedef struct packed {
      logic [2:0][63:0] s;
      logic [2:0]       c;
      logic [2:0]       o;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   full_adder_if #(.WIDTH(1))  if0 ();
   full_adder_if #(.WIDTH(8))  if1 ();
   full_adder_if #(.WIDTH(32)) if2 ();

   full_adder #(.WIDTH(1))  dut0 (.clk(clk), .rst(rst), .bus(if0));
   full_adder #(.WIDTH(8))  dut1 (.clk(clk), .rst(rst), .bus(if1));
   full_adder #(.WIDTH(32)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   logic [63:0] a_d [N_DUT];
   logic [63:0] b_d [N_DUT];
   logic [2:0]  cin_d;
   logic        en_d;
   logic [63:0] sum_o [N_DUT];
   logic [63:0] sq_o  [N_DUT];
   logic [2:0]  cout_o, cq_o, ovf_o;

   assign if0.a = a_d[0][0:0];   assign if0.b = b_d[0][0:0];
   assign if1.a = a_d[1][7:0];   assign if1.b = b_d[1][7:0];
   assign if2.a = a_d[2][31:0];  assign if2.b = b_d[2][31:0];
   assign if0.cin = cin_d[0];    assign if0.en = en_d;
   assign if1.cin = cin_d[1];    assign if1.en = en_d;
   assign if2.cin = cin_d[2];    assign if2.en = en_d;

   assign sum_o[0] = 64'(if0.sum);  assign sq_o[0] = 64'(if0.sum_q);
   assign sum_o[1] = 64'(if1.sum);  assign sq_o[1] = 64'(if1.sum_q);
   assign sum_o[2] = 64'(if2.sum);  assign sq_o[2] = 64'(if2.sum_q);
   assign cout_o = {if2.cout,   if1.cout,   if0.cout};
   assign cq_o   = {if2.cout_q, if1.cout_q, if0.cout_q};
   assign ovf_o  = {if2.ovf_q,  if1.ovf_q,  if0.ovf_q};

   // Staged inputs, applied at the next falling edge by step().
   logic [63:0] a_n [N_DUT];
   logic [63:0] b_n [N_DUT];
   logic [2:0]  cin_n;
   logic        en_n;
   logic        rst_s;

   exp_t cq[$];
   exp_t rq[$];
   exp_t regm;
   exp_t ce, re;
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic int unsigned wid(input int unsigned d);
      case (d)
         0:       return 1;
         1:       return 8;
         default: return 32;
      endcase
   endfunction

   function automatic logic [63:0] msk(input int unsigned w);
      return (w >= 64) ? '1 : ((64'(1) << w) - 64'd1);
   endfunction

   // Reference: integer addition, plus signed-range test for overflow.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input int unsigned w,
                                 output logic [63:0] s, output logic co,
                                 output logic ov);
      logic [64:0] t;
      longint      sa, sb, r, lim;
      t   = 65'(a) + 65'(b) + 65'(ci);
      s   = t[63:0] & msk(w);
      co  = t[7'(w)];
      lim = longint'(1) <<< (w - 1);
      sa  = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
      sb  = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
      r   = sa + sb + longint'(ci);
      ov  = (r >= lim) || (r < -lim);
   endfunction

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic set_in(input int unsigned d, input logic [63:0] a,
                         input logic [63:0] b, input logic ci);
      a_n[d]   = a & msk(wid(d));
      b_n[d]   = b & msk(wid(d));
      cin_n[d] = ci;
   endtask

   task automatic set_all(input logic [63:0] a, input logic [63:0] b, input logic ci);
      for (int unsigned d = 0; d < N_DUT; d++) set_in(d, a, b, ci);
   endtask

   // Apply staged inputs and push the expected combinational and register states.
   task automatic step();
      exp_t        e;
      logic [63:0] s;
      logic        co, ov;
      logic [64:0] r;
      @(negedge clk);
      rst   = rst_s;
      en_d  = en_n;
      cin_d = cin_n;
      e     = '0;
      for (int unsigned d = 0; d < N_DUT; d++) begin
         a_d[d] = a_n[d];
         b_d[d] = b_n[d];
         model(a_n[d], b_n[d], cin_n[d], wid(d), s, co, ov);
         e.s[d] = s;
         e.c[d] = co;
         e.o[d] = ov;
         r = ref_add(a_n[d], b_n[d], cin_n[d], wid(d));
         chk($sformatf("ref_add w%0d", wid(d)), r, {co, s});
      end
      cq.push_back(e);
      if (rst_s)     regm = '0;
      else if (en_n) regm = e;
      rq.push_back(regm);
   endtask

   // Combinational monitor.
   always @(negedge clk) begin
      #1;
      if (cq.size() > 0) begin
         ce = cq.pop_front();
         for (int unsigned d = 0; d < N_DUT; d++) begin
            chk($sformatf("sum w%0d", wid(d)),  65'(sum_o[d]),  65'(ce.s[d]));
            chk($sformatf("cout w%0d", wid(d)), 65'(cout_o[d]), 65'(ce.c[d]));
         end
      end
   end

   // Registered-output monitor, one cycle after each applied vector.
   always @(posedge clk) begin
      #1;
      if (rq.size() > 0) begin
         re = rq.pop_front();
         for (int unsigned d = 0; d < N_DUT; d++) begin
            chk($sformatf("sum_q w%0d", wid(d)),  65'(sq_o[d]),  65'(re.s[d]));
            chk($sformatf("cout_q w%0d", wid(d)), 65'(cq_o[d]),  65'(re.c[d]));
            chk($sformatf("ovf_q w%0d", wid(d)),  65'(ovf_o[d]), 65'(re.o[d]));
         end
      end
   end

   initial begin
      rst   = 1'b1;
      rst_s = 1'b1;
      en_d  = 1'b0;
      en_n  = 1'b0;
      cin_d = '0;
      cin_n = '0;
      regm  = '0;
      for (int unsigned d = 0; d < N_DUT; d++) begin
         a_d[d] = '0; b_d[d] = '0; a_n[d] = '0; b_n[d] = '0;
      end
      #1;
      for (int unsigned d = 0; d < N_DUT; d++) begin
         chk($sformatf("reset sum_q w%0d", wid(d)), 65'(sq_o[d]), 65'd0);
         chk($sformatf("reset cout_q w%0d", wid(d)), 65'(cq_o[d]), 65'd0);
         chk($sformatf("reset ovf_q w%0d", wid(d)), 65'(ovf_o[d]), 65'd0);
         chk($sformatf("zero sum w%0d", wid(d)), {cout_o[d], sum_o[d]}, 65'd0);
      end
      step();
      step();
      rst_s = 1'b0;
      en_n  = 1'b1;

      // Exhaustive 1-bit truth table.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         set_all(64'(v[2]), 64'(v[1]), v[0]);
         step();
      end

      // All-ones wrap-around boundaries.
      for (int unsigned d = 0; d < N_DUT; d++) set_in(d, '1, '0, 1'b1);
      step();
      for (int unsigned d = 0; d < N_DUT; d++) set_in(d, '1, '1, 1'b1);
      step();

      // Positive overflow into the sign bit.
      set_in(0, 64'd0, 64'd0, 1'b1);
      set_in(1, 64'h7F, 64'h01, 1'b0);
      set_in(2, 64'h7FFF_FFFF, 64'h1, 1'b0);
      step();
      step();

      // Asynchronous reset asserted between edges.
      #3;
      rst   = 1'b1;
      rst_s = 1'b1;
      rq.delete();
      regm  = '0;
      #1;
      for (int unsigned d = 0; d < N_DUT; d++) begin
         chk($sformatf("async rst sum_q w%0d", wid(d)), 65'(sq_o[d]), 65'd0);
         chk($sformatf("async rst cout_q w%0d", wid(d)), 65'(cq_o[d]), 65'd0);
         chk($sformatf("async rst ovf_q w%0d", wid(d)), 65'(ovf_o[d]), 65'd0);
      end
      step();
      rst_s = 1'b0;
      set_in(0, 64'd1, 64'd1, 1'b0);
      set_in(1, 64'hC8, 64'h64, 1'b1);
      set_in(2, 64'h8000_0000, 64'h8000_0000, 1'b0);
      step();

      // Hold: registers frozen while inputs keep moving.
      en_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         for (int unsigned d = 0; d < N_DUT; d++)
            set_in(d, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
         step();
      end

      // Random vectors with occasional enable drops.
      for (int unsigned i = 0; i < N_RAND; i++) begin
         en_n = ($urandom_range(0, 7) != 0);
         for (int unsigned d = 0; d < N_DUT; d++)
            set_in(d, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
         step();
      end

      repeat (2) @(negedge clk);
      #2;
      chk("scoreboard drained", 65'(cq.size() + rq.size()), 65'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
